// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer.
// It takes exceptions, mret and (optionally) interrupts from the commit stage
// and produces the mcause/mepc/mtval/mstatus update for the CSR file. It also
// drives the write strobes and holds the pipeline until the redirect is issued.
// Optional feature macro: TRAP_CTRL_IRQ_EN enables interrupt arbitration.
// Without it the irq_*_i inputs are ignored and mcause_o[31] stays 0.
module trap_ctrl #(
    parameter logic [1:0] RESET_MPP = 2'b11
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic        exc_ebreak_i,
    input  logic        exc_ialign_i,
    input  logic        exc_illegal_i,
    input  logic        exc_ecall_i,
    input  logic        exc_lalign_i,
    input  logic        exc_salign_i,
    input  logic [31:0] tval_i,
    input  logic        mret_i,
    input  logic        irq_ext_i,
    input  logic        irq_sw_i,
    input  logic        irq_timer_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mepc_i,
    input  logic [31:0] mcause_i,
    input  logic [31:0] mtval_i,
    input  logic [31:0] exc_ret_addr_i,
    output logic        we_exc_o,
    output logic        sel_exc_nret_o,
    output logic [31:0] mcause_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mtval_o,
    output logic [31:0] mstatus_o,
    output logic        busy_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRAP_WR  = 2'd1,
        RET_WR   = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic        redirect_q, redirect_d;
    logic        busy_q, busy_d;
    logic        sel_q, sel_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mtval_q, mtval_d;
    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        exc_any;
    logic [31:0] exc_cause;
    logic        req_exc;
    logic        req_ret;
    logic        req_irq;
    logic [31:0] irq_cause;

    // mstatus on trap entry: stash MIE into MPIE, disable interrupts, set MPP.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r       = ms;
        r[7]    = ms[3];
        r[3]    = 1'b0;
        r[12:11] = RESET_MPP;
        return r;
    endfunction

    // mstatus on mret: restore MIE from MPIE and set MPIE; MPP is untouched.
    function automatic logic [31:0] ret_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r    = ms;
        r[3] = ms[7];
        r[7] = 1'b1;
        return r;
    endfunction

    // Fixed-priority exception cause encoder.
    function automatic logic [31:0] exc_code(input logic ebreak, input logic ialign,
                                              input logic illegal, input logic ecall,
                                              input logic lalign, input logic salign);
        logic [31:0] c;
        if (ebreak)       c = 32'd3;
        else if (ialign)  c = 32'd0;
        else if (illegal) c = 32'd2;
        else if (ecall)   c = 32'd11;
        else if (lalign)  c = 32'd4;
        else if (salign)  c = 32'd6;
        else              c = 32'd0;
        return c;
    endfunction

    assign exc_any = exc_ebreak_i | exc_ialign_i | exc_illegal_i |
                     exc_ecall_i  | exc_lalign_i | exc_salign_i;
    assign exc_cause = exc_code(exc_ebreak_i, exc_ialign_i, exc_illegal_i,
                                exc_ecall_i, exc_lalign_i, exc_salign_i);

    // Exceptions win over mret, and mret wins over interrupts.
    assign req_exc = valid_i & exc_any;
    assign req_ret = valid_i & ~exc_any & mret_i;

`ifdef TRAP_CTRL_IRQ_EN
    logic irq_ext_en;
    logic irq_sw_en;
    logic irq_timer_en;
    logic unused_mie;

    assign irq_ext_en   = irq_ext_i   & mie_i[11];
    assign irq_sw_en    = irq_sw_i    & mie_i[3];
    assign irq_timer_en = irq_timer_i & mie_i[7];
    assign req_irq = valid_i & ~exc_any & ~mret_i & mstatus_i[3] &
                     (irq_ext_en | irq_sw_en | irq_timer_en);
    assign irq_cause = irq_ext_en ? 32'h8000_000B :
                       irq_sw_en  ? 32'h8000_0003 :
                                    32'h8000_0007;
    assign unused_mie = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};
`else
    logic unused_irq;

    assign req_irq    = 1'b0;
    assign irq_cause  = 32'h0000_0000;
    assign unused_irq = ^{irq_ext_i, irq_sw_i, irq_timer_i, mie_i};
`endif

    // Next-state and next-output logic; everything holds unless a step updates it.
    always_comb begin
        state_d       = state_q;
        we_d          = 1'b0;
        redirect_d    = 1'b0;
        sel_d         = sel_q;
        mcause_d      = mcause_q;
        mepc_d        = mepc_q;
        mtval_d       = mtval_q;
        mstatus_d     = mstatus_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            IDLE: begin
                if (req_exc || req_irq) begin
                    state_d   = TRAP_WR;
                    we_d      = 1'b1;
                    sel_d     = 1'b0;
                    mcause_d  = req_exc ? exc_cause : irq_cause;
                    mepc_d    = pc_i;
                    mtval_d   = req_exc ? tval_i : 32'h0000_0000;
                    mstatus_d = trap_mstatus(mstatus_i);
                end else if (req_ret) begin
                    state_d   = RET_WR;
                    we_d      = 1'b1;
                    sel_d     = 1'b1;
                    mcause_d  = mcause_i;
                    mepc_d    = mepc_i;
                    mtval_d   = mtval_i;
                    mstatus_d = ret_mstatus(mstatus_i);
                end
            end
            TRAP_WR, RET_WR: begin
                state_d       = REDIRECT;
                redirect_d    = 1'b1;
                redirect_pc_d = exc_ret_addr_i;
            end
            REDIRECT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any sequence and zeroes outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            redirect_q    <= 1'b0;
            busy_q        <= 1'b0;
            sel_q         <= 1'b0;
            mcause_q      <= 32'h0000_0000;
            mepc_q        <= 32'h0000_0000;
            mtval_q       <= 32'h0000_0000;
            mstatus_q     <= 32'h0000_0000;
            redirect_pc_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            redirect_q    <= redirect_d;
            busy_q        <= busy_d;
            sel_q         <= sel_d;
            mcause_q      <= mcause_d;
            mepc_q        <= mepc_d;
            mtval_q       <= mtval_d;
            mstatus_q     <= mstatus_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign we_exc_o       = we_q;
    assign redirect_o     = redirect_q;
    assign busy_o         = busy_q;
    assign sel_exc_nret_o = sel_q;
    assign mcause_o       = mcause_q;
    assign mepc_o         = mepc_q;
    assign mtval_o        = mtval_q;
    assign mstatus_o      = mstatus_q;
    assign redirect_pc_o  = redirect_pc_q;

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap sequencer for the machine-mode CSR file. It arbitrates synchronous exceptions, pending interrupts and `mret` from the pipeline, and computes the new `mcause`/`mepc`/`mtval`/`mstatus` values. It drives the CSR file's `we_exc`/`sel_exc_nret` strobes and holds the pipeline until the redirect PC (`mtvec` or `mepc`) is issued. It sits between the execute/commit stage and the CSR file.

## Interface
- `RESET_MPP`, default 2'b11: value written to `mstatus.MPP` on trap entry and left in place on return.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `valid_i` in 1: the instruction at commit (`pc_i`) is valid; requests are sampled only when this is high.
- `pc_i` in 32: PC of the committing instruction.
- `exc_ebreak_i`, `exc_ialign_i`, `exc_illegal_i`, `exc_ecall_i`, `exc_lalign_i`, `exc_salign_i` in 1 each: exception sources.
- `tval_i` in 32: faulting address or instruction word for the current exception.
- `mret_i` in 1: the committing instruction is `mret`.
- `irq_ext_i`, `irq_sw_i`, `irq_timer_i` in 1 each: level interrupt lines.
- `mstatus_i`, `mie_i`, `mepc_i`, `mcause_i`, `mtval_i` in 32 each: current CSR values.
- `exc_ret_addr_i` in 32: CSR file target (`mepc` when sel=1, `mtvec` when sel=0).
- `we_exc_o` out 1: CSR write strobe.
- `sel_exc_nret_o` out 1: selects `mepc` when 1 (return), `mtvec` when 0 (trap).
- `mcause_o`, `mepc_o`, `mtval_o`, `mstatus_o` out 32 each: values written when `we_exc_o`=1.
- `busy_o` out 1: pipeline stall/flush request.
- `redirect_o` out 1: one-cycle PC redirect strobe.
- `redirect_pc_o` out 32: redirect target, valid with `redirect_o`.

## Operation
- FSM states: IDLE, TRAP_WR, RET_WR, REDIRECT.
- IDLE, `valid_i`=1, any exception → TRAP_WR. The cause is chosen by fixed priority:
  - ebreak → 3
  - ialign → 0
  - illegal → 2
  - ecall → 11
  - lalign → 4
  - salign → 6
- IDLE, `valid_i`=1, no exception, `mret_i`=1 → RET_WR.
- IDLE, `valid_i`=1, no exception, no mret, `mstatus_i[3]`=1, and (irq & `mie_i`) nonzero → TRAP_WR with an interrupt cause: external → 0x8000000B, software → 0x80000003, timer → 0x80000007 (in that priority). Interrupt enables are `mie_i` bits 11, 3 and 7.
- Captured on accept:
  - exception: mepc = `pc_i`, mtval = `tval_i`.
  - interrupt: mepc = `pc_i` (the instruction is not executed), mtval = 0.
- TRAP_WR: `we_exc_o`=1, `sel_exc_nret_o`=0. `mstatus_o` = `mstatus_i` with MPIE(7) ← MIE(3), MIE ← 0, MPP(12:11) ← `RESET_MPP`. Next state REDIRECT.
- RET_WR: `we_exc_o`=1, `sel_exc_nret_o`=1. `mepc_o`/`mcause_o`/`mtval_o` pass through the current `*_i` values. `mstatus_o`: MIE ← MPIE, MPIE ← 1. Next state REDIRECT.
- REDIRECT: `redirect_o`=1, `redirect_pc_o` = `exc_ret_addr_i`. `sel_exc_nret_o` is held from the previous state. Next state IDLE.
- Exception always beats `mret_i` and interrupts in the same cycle.
- Requests arriving while not in IDLE are ignored; the pipeline is stalled by `busy_o`.
- When `we_exc_o`=0, the `*_o` data outputs hold their last values.

## Timing
- Accept cycle N (IDLE): combinational decode only, no outputs asserted.
- Cycle N+1: `we_exc_o`=1 and `busy_o`=1.
- Cycle N+2: `redirect_o`=1 and `busy_o`=1.
- Cycle N+3: back in IDLE. A new request can be accepted in N+3.
- `busy_o`=1 in TRAP_WR, RET_WR and REDIRECT; 0 in IDLE.
- `we_exc_o`, `redirect_o` and `busy_o` are registered.
- Reset (async, `rst_i`=0), including mid-sequence: FSM → IDLE. All outputs are 0, including all data outputs and `sel_exc_nret_o`. An interrupted sequence is abandoned with no partial write.
- Back-to-back: an exception in N+3 following an `mret` is accepted normally.

## Configuration
- `TRAP_CTRL_IRQ_EN` defined: interrupt arbitration as described.
- `TRAP_CTRL_IRQ_EN` undefined:
  - the `irq_*_i` ports remain but are ignored;
  - only exceptions and `mret` are sequenced;
  - `mcause_o[31]` is always 0.

## Test plan
- Illegal instruction with `pc_i`=0x100, `tval_i`=0x0000FFFF, mstatus=0x8 → N+1: we_exc=1, mcause=2, mepc=0x100, mtval=0xFFFF, mstatus=0x1880; N+2: redirect=1, pc=`exc_ret_addr_i`, sel=0.
- ebreak and ecall together → mcause=3 only.
- `mret_i` with mstatus=0x1880, mepc=0x104 → N+1: we_exc=1, sel=1, mstatus=0x1888, mepc_o=0x104; N+2: redirect to `exc_ret_addr_i`.
- Timer IRQ with mie=0x80, mstatus=0x8 → mcause=0x80000007, mtval=0. With mstatus=0 → no trap. With ext+timer pending and mie=0x880 → mcause=0x8000000B.
- Illegal + timer IRQ + `mret_i` in the same cycle → mcause=2, sel=0. A second request during busy is ignored.
- `rst_i` low during TRAP_WR → all outputs 0 and IDLE; after release, the next request sequences normally. With the macro undefined, IRQ stimulus produces no trap.
